onchip_mem_pipe: RTL and testbench
==================================

Name: onchip_mem_pipe

Overview:
- Parametrised Avalon-MM on-chip RAM slave; successor to the fixed 32-bit, single-latency on-chip memory.
- Adds configurable width, depth and read latency (1 or 2).
- Adds readdatavalid/waitrequest handshake, a power-on zero-fill state machine, and out-of-range address handling.
- Sits on the system interconnect as a pipelined-read slave.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 15, word-address width.
- DEPTH, 32000, number of words; must be ≤ 2^ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset before accepting traffic.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  clock enable; 0 = stall.
- reset_req  in  1  reset-request stall; 1 = stall.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  byte lane enables for writes.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  readdata qualifier.
- waitrequest  out  1  slave busy/stalled.
- init_done  out  1  zero-fill complete.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Outputs: readdata=0, readdatavalid=0, init_done=0, waitrequest=1.
  - Read pipeline cleared; fill counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
- Stall: en = clken & ~reset_req.
  - While en=0: waitrequest=1, no RAM access, pipeline and counter hold.
  - readdatavalid is forced 0 while stalled and resumes when en returns.
- FSM CLEAR:
  - Each en cycle writes all-zero (all lanes) to word fill_cnt, then increments fill_cnt.
  - At fill_cnt=DEPTH-1 the last word is written and the FSM moves to READY next cycle.
  - waitrequest=1 throughout CLEAR.
  - Zero-fill takes exactly DEPTH en-cycles.
- FSM READY:
  - init_done=1.
  - waitrequest = ~en; a command is accepted when chipselect & ~waitrequest.
- Write: chipselect & write accepted.
  - Each byte lane i is updated iff byteenable[i]; other lanes keep their value.
  - No response is generated.
- Read: chipselect & read & ~write accepted.
  - readdata/readdatavalid are presented exactly READ_LATENCY en-cycles later.
  - Fully pipelined: one read accepted per cycle; responses in order.
- read & write both asserted: treated as a write; no read response.
- Out of range (address ≥ DEPTH): writes are dropped; reads return 0 with a normal readdatavalid.
- Write then read of the same address on the next cycle returns the new data.
- readdata holds its last value when readdatavalid=0.
- reset_n asserted mid-CLEAR: the fill restarts from word 0.
- reset_n asserted with reads in flight: those reads are discarded, no readdatavalid.

Optional Feature:
- Macro ONCHIP_MEM_PARITY_EN.
- Defined:
  - Each byte lane stores one extra even-parity bit, written alongside the byte.
  - Zero-fill writes parity 0.
  - On read, parity is recomputed for all lanes; output parity_err (1 bit, reset 0) pulses with readdatavalid when any lane mismatches.
  - Out-of-range reads never flag.
- Not defined: no parity storage and no parity_err port.

Decomposition:
- Package onchip_mem_pkg:
  - FSM state enum {CLEAR, READY}.
  - Legal READ_LATENCY constants (1, 2).
  - Function computing byte-lane count (DATA_W/8).
- Sub-module onchip_mem_ram: behavioural byte-enabled single-port array with synchronous read; optional parity storage.
- Top level holds the FSM, stall logic, range check and response pipeline.

Test Plan:
- Zero-fill: DEPTH=16, CLEAR_ON_RESET=1; release reset → waitrequest=1 for 16 cycles, init_done rises on cycle 17, and reads of all 16 words return 0.
- Byte enables: write 0xA5A5A5A5 to addr 3, then write 0x11223344 with byteenable=4'b0101 → read returns 0xA522A544 after READ_LATENCY cycles.
- Back-to-back reads: READ_LATENCY=2, reads to addr 0,1,2 on consecutive cycles → three consecutive readdatavalid pulses in order, the first 2 cycles after the first accept.
- Stall: drop clken for 3 cycles mid-pipeline → waitrequest=1 and no readdatavalid during the stall; the pending response appears on resume with correct data.
- Out of range: DEPTH=16, write 0xFFFFFFFF to addr 20, then read addr 20 → readdata=0 with readdatavalid; word addr 4 is unchanged.
- Parity (ONCHIP_MEM_PARITY_EN): force-flip bit 9 of stored word 5, read addr 5 → parity_err=1 coincident with readdatavalid; read of addr 6 → parity_err=0.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM slave.
// Contents: FSM state enum, legal read-latency constants, byte-lane count helper.
package onchip_mem_pkg;

  // Power-on fill in progress, or serving bus traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Supported read latencies (cycles from accept to readdatavalid).
  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

  // Number of byte lanes in a data word.
  function automatic int unsigned lane_cnt(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/onchip_mem_ram.sv
// Byte-enabled single-port RAM with a registered (synchronous) read port.
// Optional macro ONCHIP_MEM_PARITY_EN adds one even-parity bit per byte lane.
// Ports:
//   clk, reset_n  clock and async active-low reset (read register only)
//   we, re        write / read strobes (never both in the same cycle)
//   addr          word index
//   be, wdata     byte-lane enables and write data
//   rdata         read data, updated only on re
//   rpar          stored parity bits of the last read word (parity build only)
module onchip_mem_ram
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32000,
  parameter int unsigned IDX_W  = 15,
  parameter int unsigned NB     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [NB-1:0]     be,
  input  logic [DATA_W-1:0] wdata,
`ifdef ONCHIP_MEM_PARITY_EN
  output logic [NB-1:0]     rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rpar_q, rpar_d;
`endif

  // Storage array: only enabled lanes are written.
  always_ff @(posedge clk) begin : p_array
    if (we) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be[i]) begin
          mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
          par_q[addr][i]        <= ^wdata[i*8 +: 8];
`endif
        end
      end
    end
  end

  // Read register holds its value between reads.
  always_comb begin : p_rd_next
    rdata_d = rdata_q;
`ifdef ONCHIP_MEM_PARITY_EN
    rpar_d  = rpar_q;
`endif
    if (re) begin
      rdata_d = mem_q[addr];
`ifdef ONCHIP_MEM_PARITY_EN
      rpar_d  = par_q[addr];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_rd_reg
    if (!reset_n) begin
      rdata_q <= '0;
`ifdef ONCHIP_MEM_PARITY_EN
      rpar_q  <= '0;
`endif
    end else begin
      rdata_q <= rdata_d;
`ifdef ONCHIP_MEM_PARITY_EN
      rpar_q  <= rpar_d;
`endif
    end
  end

  assign rdata = rdata_q;
`ifdef ONCHIP_MEM_PARITY_EN
  assign rpar  = rpar_q;
`endif

endmodule

// File: rtl/onchip_mem_pipe.sv
// Avalon-MM on-chip RAM slave with configurable width/depth, read latency 1 or 2,
// power-on zero-fill, stall inputs and out-of-range handling.
// Optional macro ONCHIP_MEM_PARITY_EN adds per-lane parity and the parity_err output.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   clken, reset_req     stall inputs (stall when clken=0 or reset_req=1)
//   chipselect/read/write/address/byteenable/writedata   Avalon command
//   readdata, readdatavalid   read response
//   waitrequest          slave busy (fill in progress or stalled)
//   init_done            zero-fill finished
//   parity_err           lane parity mismatch on a response (parity build only)
module onchip_mem_pipe
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DEPTH          = 32000,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
`ifdef ONCHIP_MEM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  init_done
);

  localparam int unsigned NB    = lane_cnt(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam state_e RST_STATE  = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                init_done_q, init_done_d;
  logic                rv1_q, rv1_d;
  logic                oor1_q, oor1_d;

  logic                en_c;
  logic                in_range_c;
  logic                wr_acc_c, rd_acc_c;
  logic                ram_we, ram_re;
  logic [IDX_W-1:0]    ram_addr;
  logic [NB-1:0]       ram_be;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;
  logic [DATA_W-1:0]   stage1_data_c;

  // Stall qualifier and command decode.
  assign en_c        = clken & ~reset_req;
  assign in_range_c  = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
  // init_done_q stays low for the first cycle after reset even without a fill,
  // which keeps waitrequest asserted while reset_n is low.
  assign waitrequest = ~(en_c & init_done_q);
  assign wr_acc_c    = chipselect & ~waitrequest & write;
  assign rd_acc_c    = chipselect & ~waitrequest & read & ~write;
  assign init_done   = init_done_q;

  // Next-state / RAM port control.
  always_comb begin : p_fsm
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = IDX_W'(address);
    ram_be      = byteenable;
    ram_wdata   = writedata;
    case (state_q)
      CLEAR: begin
        init_done_d = 1'b0;
        ram_addr    = IDX_W'(fill_cnt_q);
        ram_be      = '1;
        ram_wdata   = '0;
        if (en_c) begin
          ram_we = 1'b1;
          if (fill_cnt_q == LAST_WORD) begin
            state_d     = READY;
            fill_cnt_d  = '0;
            init_done_d = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          end
        end
      end
      READY: begin
        init_done_d = 1'b1;
        ram_we      = wr_acc_c & in_range_c;
        ram_re      = rd_acc_c & in_range_c;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_fsm_reg
    if (!reset_n) begin
      state_q     <= RST_STATE;
      fill_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // First pipeline stage; oor1 only moves on an accepted read so readdata holds.
  always_comb begin : p_stage1
    rv1_d  = en_c ? rd_acc_c : rv1_q;
    oor1_d = rd_acc_c ? ~in_range_c : oor1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_stage1_reg
    if (!reset_n) begin
      rv1_q  <= 1'b0;
      oor1_q <= 1'b0;
    end else begin
      rv1_q  <= rv1_d;
      oor1_q <= oor1_d;
    end
  end

  assign stage1_data_c = oor1_q ? '0 : ram_rdata;

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] ram_rpar;
  logic          perr1_c;

  // Recompute lane parity of the word just read; out-of-range reads never flag.
  always_comb begin : p_par_chk
    perr1_c = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      perr1_c = perr1_c | ((^ram_rdata[i*8 +: 8]) ^ ram_rpar[i]);
    end
    perr1_c = perr1_c & ~oor1_q;
  end
`endif

  onchip_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .NB     (NB)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .be      (ram_be),
    .wdata   (ram_wdata),
`ifdef ONCHIP_MEM_PARITY_EN
    .rpar    (ram_rpar),
`endif
    .rdata   (ram_rdata)
  );

  // Response stage: extra register for latency 2, direct for latency 1.
  // Valid is masked by en so a response is only ever seen in an en-cycle.
  if (READ_LATENCY == RD_LAT_2) begin : g_lat2
    logic              rv2_q, rv2_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
`ifdef ONCHIP_MEM_PARITY_EN
    logic              perr2_q, perr2_d;
`endif

    always_comb begin : p_stage2
      rv2_d    = en_c ? rv1_q : rv2_q;
      rdata2_d = rdata2_q;
`ifdef ONCHIP_MEM_PARITY_EN
      perr2_d  = perr2_q;
`endif
      if (en_c && rv1_q) begin
        rdata2_d = stage1_data_c;
`ifdef ONCHIP_MEM_PARITY_EN
        perr2_d  = perr1_c;
`endif
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_stage2_reg
      if (!reset_n) begin
        rv2_q    <= 1'b0;
        rdata2_q <= '0;
`ifdef ONCHIP_MEM_PARITY_EN
        perr2_q  <= 1'b0;
`endif
      end else begin
        rv2_q    <= rv2_d;
        rdata2_q <= rdata2_d;
`ifdef ONCHIP_MEM_PARITY_EN
        perr2_q  <= perr2_d;
`endif
      end
    end

    assign readdata      = rdata2_q;
    assign readdatavalid = rv2_q & en_c;
`ifdef ONCHIP_MEM_PARITY_EN
    assign parity_err    = perr2_q & rv2_q & en_c;
`endif
  end else begin : g_lat1
    assign readdata      = stage1_data_c;
    assign readdatavalid = rv1_q & en_c;
`ifdef ONCHIP_MEM_PARITY_EN
    assign parity_err    = perr1_c & rv1_q & en_c;
`endif
  end

endmodule

// File: tb/tb_onchip_mem_pipe.sv
// Scoreboard bench for onchip_mem_pipe (DEPTH=16, READ_LATENCY=2, zero-fill on).
// Parity scenario is compiled only with ONCHIP_MEM_PARITY_EN.
module tb_onchip_mem_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LAT    = 2;
  localparam int unsigned NB     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, clken, reset_req, chipselect, read, write;
  logic [ADDR_W-1:0] address;
  logic [NB-1:0]     byteenable;
  logic [DATA_W-1:0] writedata, readdata;
  logic              readdatavalid, waitrequest, init_done;
`ifdef ONCHIP_MEM_PARITY_EN
  logic              parity_err;
`endif

  onchip_mem_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
`ifdef ONCHIP_MEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .init_done(init_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int unsigned tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [3:0]  bad_lanes [DEPTH];
  int unsigned en_cnt = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  bit          model_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Count clock edges on which the slave is enabled.
  always @(posedge clk) begin
    if (reset_n && clken && !reset_req) en_cnt <= en_cnt + 1;
  end

  // Monitor: pop the scoreboard whenever a response is presented.
  initial begin : monitor
    exp_t        e;
    logic [31:0] last_data;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rdv_in_reset", 32'(readdatavalid), 32'd0);
        last_data = '0;
      end else if (!(clken && !reset_req)) begin
        check("rdv_stalled", 32'(readdatavalid), 32'd0);
      end else if (readdatavalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdv", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", readdata, e.data);
          check("rd_latency", en_cnt, e.tag);
`ifdef ONCHIP_MEM_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
          last_data = e.data;
        end
      end else begin
        check("rd_hold", readdata, last_data);
        if (exp_q.size() != 0 && exp_q[0].tag <= en_cnt)
          check("missing_rdv", 32'd0, 32'd1);
      end
    end
  end

  // One bus cycle: drive, evaluate acceptance from the model, advance.
  task automatic drive(input bit cs, input bit rd, input bit wr, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] d, input bit ce, input bit rq);
    exp_t       e;
    logic [3:0] ai;
    bit         inr;
    chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = d; clken = ce; reset_req = rq;
    ai  = a[3:0];
    inr = (32'(a) < DEPTH);
    @(negedge clk);
    if (model_ready) check("waitrequest", 32'(waitrequest), 32'(!(ce && !rq)));
    if (model_ready && cs && ce && !rq) begin
      if (wr) begin
        if (inr) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
              model_mem[ai][i*8 +: 8] = d[i*8 +: 8];
              bad_lanes[ai][i] = 1'b0;
            end
          end
        end
      end else if (rd) begin
        e.data = inr ? model_mem[ai] : 32'd0;
        e.perr = inr && (bad_lanes[ai] != 4'd0);
        e.tag  = en_cnt + LAT;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cmd(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(1'b1, 1'b0, 1'b1, a, be, d, 1'b1, 1'b0);
  endtask

  task automatic rd_cmd(input logic [4:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic idle(input bit ce, input bit rq);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0, ce, rq);
  endtask

  // Assert reset (inputs idle, bench model cleared) and release just after an edge.
  task automatic apply_reset(input int cycles);
    reset_n = 1'b0; model_ready = 1'b0; exp_q.delete();
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_readdata", readdata, 32'd0);
      check("rst_waitrequest", 32'(waitrequest), 32'd1);
      check("rst_init_done", 32'(init_done), 32'd0);
      @(posedge clk);
    end
    #1 reset_n = 1'b1;
  endtask

  // Fill takes DEPTH enabled cycles; init_done appears on the following cycle.
  task automatic check_fill();
    for (int c = 0; c < int'(DEPTH); c++) begin
      @(negedge clk);
      check("fill_waitrequest", 32'(waitrequest), 32'd1);
      check("fill_init_done", 32'(init_done), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("init_done_rise", 32'(init_done), 32'd1);
    check("ready_waitrequest", 32'(waitrequest), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      model_mem[i] = '0;
      bad_lanes[i] = '0;
    end
    model_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int unsigned r;
    logic [4:0]  ra;
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;

    // Reset interrupted mid-fill, then a full fill.
    apply_reset(3);
    repeat (5) @(posedge clk);
    #1;
    apply_reset(2);
    check_fill();

    // All words read back as zero, back-to-back.
    for (int i = 0; i < int'(DEPTH); i++) rd_cmd(5'(i));
    repeat (4) idle(1'b1, 1'b0);

    // Byte-lane merge.
    wr_cmd(5'd3, 4'hF, 32'hA5A5_A5A5);
    wr_cmd(5'd3, 4'b0101, 32'h1122_3344);
    rd_cmd(5'd3);
    repeat (3) idle(1'b1, 1'b0);

    // Write followed immediately by a read of the same word; read+write counts as write.
    wr_cmd(5'd7, 4'hF, 32'hDEAD_BEEF);
    rd_cmd(5'd7);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 4'h3, 32'h0000_1234, 1'b1, 1'b0);
    rd_cmd(5'd7);
    repeat (3) idle(1'b1, 1'b0);

    // Out-of-range write dropped; read returns zero; neighbour untouched.
    wr_cmd(5'd4, 4'hF, 32'h0404_0404);
    wr_cmd(5'd20, 4'hF, 32'hFFFF_FFFF);
    rd_cmd(5'd20);
    rd_cmd(5'd4);
    repeat (3) idle(1'b1, 1'b0);

    // Stall mid-pipeline with clken, then with reset_req.
    rd_cmd(5'd0); rd_cmd(5'd3); rd_cmd(5'd7);
    repeat (3) idle(1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    rd_cmd(5'd4); rd_cmd(5'd3);
    repeat (2) idle(1'b1, 1'b1);
    repeat (3) idle(1'b1, 1'b0);

`ifdef ONCHIP_MEM_PARITY_EN
    // Corrupt one stored bit behind the model's back.
    wr_cmd(5'd5, 4'hF, 32'h1357_9BDF);
    wr_cmd(5'd6, 4'hF, 32'h2468_ACE0);
    dut.u_ram.mem_q[5][9] = ~dut.u_ram.mem_q[5][9];
    model_mem[5][9] = ~model_mem[5][9];
    bad_lanes[5][1] = 1'b1;
    rd_cmd(5'd5);
    rd_cmd(5'd6);
    repeat (3) idle(1'b1, 1'b0);
`endif

    // Randomized traffic with occasional stalls and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      ra = 5'($urandom_range(0, 19));
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ra, 4'($urandom_range(0, 15)), $urandom(), (r >= 8), (r < 3));
    end

    // Reset with reads in flight: those responses must never appear.
    rd_cmd(5'd1); rd_cmd(5'd2);
    apply_reset(2);
    check_fill();
    rd_cmd(5'd3);

    // Bounded drain of outstanding responses.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1'b1, 1'b0);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) idle(1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
